// File: rtl/sg_normalize_if.sv
// sg_normalize_if: handshake bundle between the significand multiplier, the
// normalizer and the accumulator adder.
// Ports: upstream product (in_*) with valid/ready, downstream result (out_*) with valid/ready.
interface sg_normalize_if;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] in_sig_mul_out;
  logic [6:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_frac;
  logic [4:0]  out_exp;
  logic        out_zero;
  logic        out_ovf;
  logic        out_unf;

  // Normalizer side.
  modport slave (
    input  in_valid, in_sig_mul_out, in_exp, out_ready,
    output in_ready, out_valid, out_frac, out_exp, out_zero, out_ovf, out_unf
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_sig_mul_out, in_exp, out_ready,
    input  in_ready, out_valid, out_frac, out_exp, out_zero, out_ovf, out_unf
  );
endinterface

// File: rtl/sg_normalize.sv
// sg_normalize: post-multiply normalizer/rounder for the half-precision MAC.
// Latency: accept at E0, out_valid after E3; one transaction in flight, 5-cycle minimum period.
// Backpressure: result held in HOLD until out_ready; in_ready only in IDLE.
// Ports: clock, resetn (async active-low), bus (sg_normalize_if.slave).
// Option: define SG_NORMALIZE_ROUND_EN for round-to-nearest-even; default truncates.
module sg_normalize #(
  parameter int EXP_BIAS = 15
) (
  input logic           clock,
  input logic           resetn,
  sg_normalize_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DETECT, NORM, ROUND, HOLD} state_t;

  localparam logic signed [7:0] OVF_TH = 8'(2 * EXP_BIAS + 1);

  state_t state_q, state_d;

  // Captured operands and intermediate stage registers.
  logic [21:0]       sig_q;
  logic [6:0]        exp_q;
  logic [4:0]        pos_q;
  logic              zero_q;
  logic [9:0]        frac_q;
  logic signed [7:0] e_q;
`ifdef SG_NORMALIZE_ROUND_EN
  logic              grd_q;
  logic              stk_q;
`endif

  // Result registers, written only on ROUND->HOLD.
  logic [9:0] out_frac_q;
  logic [4:0] out_exp_q;
  logic       out_zero_q;
  logic       out_ovf_q;
  logic       out_unf_q;

  // Leading-one position; 21 doubles as the all-zero code.
  logic [4:0] lead_pos;
  always_comb begin
    lead_pos = 5'd21;
    for (int i = 0; i < 22; i++) begin
      if (sig_q[i]) lead_pos = 5'(i);
    end
  end

  // Left-justify so the hidden one lands at bit 21. Only bits [20:0] of the
  // justified value matter, so the shift is done on 21 bits and only the
  // fields the ROUND stage needs are kept.
  logic [4:0]        shamt;
  logic [9:0]        frac_n;
  logic signed [7:0] e_n;
  always_comb begin
    shamt  = 5'd21 - pos_q;
    frac_n = 10'((sig_q[20:0] << shamt) >> 11);
    e_n    = {exp_q[6], exp_q} + {3'b000, pos_q} - 8'd20;
  end

`ifdef SG_NORMALIZE_ROUND_EN
  logic [10:0] lo_n;
  logic        grd_n;
  logic        stk_n;
  always_comb begin
    lo_n  = 11'(sig_q[20:0] << shamt);
    grd_n = lo_n[10];
    stk_n = |lo_n[9:0];
  end
`endif

  // Rounding and range classification.
  logic [9:0]        f_rnd;
  logic signed [7:0] e_rnd;
  always_comb begin
`ifdef SG_NORMALIZE_ROUND_EN
    logic       inc;
    logic       carry;
    inc            = grd_q & (stk_q | frac_q[0]);
    {carry, f_rnd} = {1'b0, frac_q} + {10'd0, inc};
    // A carry out of the fraction means 1.111..1 rounded up to 10.0: the
    // wrapped fraction is already zero, only the exponent moves.
    e_rnd          = e_q + {7'd0, carry};
`else
    f_rnd = frac_q;
    e_rnd = e_q;
`endif
  end

  logic [9:0] res_frac;
  logic [4:0] res_exp;
  logic       res_zero;
  logic       res_ovf;
  logic       res_unf;
  always_comb begin
    res_frac = 10'd0;
    res_exp  = 5'd0;
    res_zero = 1'b0;
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
    if (zero_q) begin
      res_zero = 1'b1;
    end else if (e_rnd <= 8'sd0) begin
      res_unf = 1'b1;
    end else if (e_rnd >= OVF_TH) begin
      res_ovf = 1'b1;
      res_exp = 5'd31;
    end else begin
      res_exp  = e_rnd[4:0];
      res_frac = f_rnd;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = DETECT;
      DETECT:  state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      sig_q      <= '0;
      exp_q      <= '0;
      pos_q      <= '0;
      zero_q     <= 1'b0;
      frac_q     <= '0;
      e_q        <= '0;
`ifdef SG_NORMALIZE_ROUND_EN
      grd_q      <= 1'b0;
      stk_q      <= 1'b0;
`endif
      out_frac_q <= '0;
      out_exp_q  <= '0;
      out_zero_q <= 1'b0;
      out_ovf_q  <= 1'b0;
      out_unf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sig_q <= bus.in_sig_mul_out;
            exp_q <= bus.in_exp;
          end
        end
        DETECT: begin
          pos_q  <= lead_pos;
          zero_q <= ~|sig_q;
        end
        NORM: begin
          frac_q <= frac_n;
          e_q    <= e_n;
`ifdef SG_NORMALIZE_ROUND_EN
          grd_q  <= grd_n;
          stk_q  <= stk_n;
`endif
        end
        ROUND: begin
          out_frac_q <= res_frac;
          out_exp_q  <= res_exp;
          out_zero_q <= res_zero;
          out_ovf_q  <= res_ovf;
          out_unf_q  <= res_unf;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_frac  = out_frac_q;
  assign bus.out_exp   = out_exp_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_unf   = out_unf_q;

endmodule

// File: tb/tb_sg_normalize.sv
// tb_sg_normalize: directed and randomized checks of sg_normalize against an
// arithmetic reference model (leading one via log2, rounding via quotient/remainder).
module tb_sg_normalize;
  localparam int BIAS = 15;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  sg_normalize_if bus();

  sg_normalize #(.EXP_BIAS(BIAS)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Reference: value = sig * 2^(in_exp-20); normalize to 1.f and round the
  // 21-bit-justified mantissa to 11 significant bits.
  task automatic model(input logic [21:0] sig, input logic [6:0] ex,
                       output logic [9:0] f, output logic [4:0] e5,
                       output logic z, output logic o, output logic u);
    int p, e, full, q, r;
    f = '0; e5 = '0; z = 1'b0; o = 1'b0; u = 1'b0;
    if (sig == 22'd0) begin
      z = 1'b1;
    end else begin
      p    = $clog2(int'(sig) + 1) - 1;
      e    = int'($signed(ex)) + p - 20;
      full = int'(sig) * (1 << (21 - p));
      q    = full / 2048;
      r    = full % 2048;
`ifdef SG_NORMALIZE_ROUND_EN
      if (r > 1024 || (r == 1024 && (q % 2) == 1)) q++;
      if (q == 2048) begin
        q = 1024;
        e++;
      end
`endif
      if (e <= 0) u = 1'b1;
      else if (e >= 2 * BIAS + 1) begin
        o  = 1'b1;
        e5 = 5'd31;
      end else begin
        f  = 10'(q - 1024);
        e5 = 5'(e);
      end
    end
  endtask

  task automatic run_txn(input logic [21:0] sig, input logic [6:0] ex, input int hold);
    logic [9:0] mf;
    logic [4:0] me;
    logic       mz, mo, mu;
    model(sig, ex, mf, me, mz, mo, mu);
    @(negedge clock);
    bus.in_valid       = 1'b1;
    bus.in_sig_mul_out = sig;
    bus.in_exp         = ex;
    bus.out_ready      = (hold == 0);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clock); #1;
    chk("busy_e0", {bus.in_ready, bus.out_valid}, 32'd0);
    // Garbage with in_valid still high must be ignored while busy.
    bus.in_sig_mul_out = 22'($urandom);
    bus.in_exp         = 7'($urandom);
    @(posedge clock); #1;
    chk("busy_e1", {bus.in_ready, bus.out_valid}, 32'd0);
    @(posedge clock); #1;
    chk("busy_e2", {bus.in_ready, bus.out_valid}, 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
    chk("valid_e3", {bus.in_ready, bus.out_valid}, 32'd1);
    chk("frac", 32'(bus.out_frac), 32'(mf));
    chk("exp", 32'(bus.out_exp), 32'(me));
    chk("flags_zou", {bus.out_zero, bus.out_ovf, bus.out_unf}, {mz, mo, mu});
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      chk("hold_hs", {bus.in_ready, bus.out_valid}, 32'd1);
      chk("hold_stable", {bus.out_frac, bus.out_exp, bus.out_zero, bus.out_ovf, bus.out_unf},
          {mf, me, mz, mo, mu});
    end
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    chk("release", {bus.in_ready, bus.out_valid}, 32'b10);
  endtask

  initial begin
    logic [21:0] rs;
    logic [6:0]  rx;
    bus.in_valid       = 1'b0;
    bus.in_sig_mul_out = '0;
    bus.in_exp         = '0;
    bus.out_ready      = 1'b1;

    // Reset state.
    #12;
    chk("rst_hs", {bus.in_ready, bus.out_valid}, 32'b10);
    chk("rst_out", {bus.out_frac, bus.out_exp, bus.out_zero, bus.out_ovf, bus.out_unf}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    // Directed cases.
    run_txn(22'h200000, 7'd15, 0);   // exp 16, frac 0
    run_txn(22'h100000, 7'd15, 0);   // exp 15
    run_txn(22'h000001, 7'd40, 0);   // maximum shift, exp 20
    run_txn(22'h1FFFFF, 7'd15, 0);   // rounding carry (or truncation to 3FF)
    run_txn(22'h000000, 7'd15, 0);   // zero
    run_txn(22'h200000, 7'd30, 0);   // overflow
    run_txn(22'h100000, 7'd0,  0);   // underflow
    run_txn(22'h100600, 7'd10, 0);   // exact tie, odd fraction
    run_txn(22'h100200, 7'd10, 0);   // exact tie, even fraction
    run_txn(22'h2ABCDE, 7'd12, 10);  // backpressure for 10 cycles

    // Reset while in NORM discards the operation and clears a held result.
    run_txn(22'h200000, 7'd15, 0);
    @(negedge clock);
    bus.in_valid       = 1'b1;
    bus.in_sig_mul_out = 22'h1FFFFF;
    bus.in_exp         = 7'd15;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    @(posedge clock); #3;
    resetn = 1'b0;
    #1;
    chk("rstnorm_hs", {bus.in_ready, bus.out_valid}, 32'b10);
    chk("rstnorm_out", {bus.out_frac, bus.out_exp, bus.out_zero, bus.out_ovf, bus.out_unf}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      chk("no_stale", {bus.out_valid, bus.out_exp, bus.out_frac}, 32'd0);
    end

    // Randomized transactions.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: rs = 22'($urandom);
        3, 4:    rs = 22'($urandom) >> $urandom_range(0, 21);
        5, 6:    rs = 22'h100200 | (22'($urandom_range(0, 1023)) << 10);
        default: rs = 22'd0;
      endcase
      if ($urandom_range(0, 1) == 1) rx = 7'($urandom_range(0, 127));
      else                           rx = 7'($urandom_range(5, 30));
      run_txn(rs, rx, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
